// File: rtl/rad_q14_to_int_deg.sv
// rtl/rad_q14_to_int_deg.sv - signed Q2.14 radians to signed integer degrees, start/done FSM
// Optional range saturation to +/-LIMIT_DEG is built only when RANGE_CHECK_EN is defined.
`ifndef INPUTOUTBIT
`define INPUTOUTBIT 16
`endif

module rad_q14_to_int_deg #(
    parameter logic [11:0] K_RAD2DEG  = 12'd3667,
`ifdef RANGE_CHECK_EN
    parameter int          LIMIT_DEG  = 90,
`endif
    parameter int          FRAC_SHIFT = 20
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    start,
    input  logic [15:0]             rad_q14,
    output logic [`INPUTOUTBIT-1:0] deg_out,
    output logic                    deg_valid,
    output logic                    busy,
    output logic                    error,
    output logic                    done
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ABS,
        S_MUL,
        S_RND,
        S_OUT,
        S_DONE
    } state_t;

    localparam logic [28:0] RND_HALF = 29'd1 << (FRAC_SHIFT - 1);

    state_t                  r_state;
    state_t                  w_next;

    logic [15:0]             r_rad;
    logic                    r_sign;
    logic [16:0]             r_mag;
    logic [28:0]             r_prod;
    logic [8:0]              r_mag_deg;
    logic [`INPUTOUTBIT-1:0] r_deg_out;
    logic                    r_deg_valid;
    logic                    r_done;

    logic [16:0]             w_rad_ext;
    logic [16:0]             w_mag;
    logic [28:0]             w_prod;
    logic [8:0]              w_mag_sel;
    logic [`INPUTOUTBIT-1:0] w_mag_ext;
    logic [`INPUTOUTBIT-1:0] w_deg_val;

    // 17-bit magnitude so that -32768 maps to +32768 without wrapping
    assign w_rad_ext = {r_rad[15], r_rad};
    assign w_mag     = r_rad[15] ? (17'd0 - w_rad_ext) : w_rad_ext;
    assign w_prod    = 29'(r_mag) * 29'(K_RAD2DEG);

`ifdef RANGE_CHECK_EN
    logic w_over;
    logic r_error;

    assign w_over    = (r_mag_deg > 9'(LIMIT_DEG));
    assign w_mag_sel = w_over ? 9'(LIMIT_DEG) : r_mag_deg;
    assign error     = r_error;
`else
    assign w_mag_sel = r_mag_deg;
    assign error     = 1'b0;
`endif

    // Negating a zero magnitude yields zero, so there is no negative-zero case
    assign w_mag_ext = `INPUTOUTBIT'(w_mag_sel);
    assign w_deg_val = r_sign ? (`INPUTOUTBIT'(0) - w_mag_ext) : w_mag_ext;

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:  if (start) w_next = S_ABS;
            S_ABS:   w_next = S_MUL;
            S_MUL:   w_next = S_RND;
            S_RND:   w_next = S_OUT;
            S_OUT:   w_next = S_DONE;
            S_DONE:  w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_rad       <= '0;
            r_sign      <= 1'b0;
            r_mag       <= '0;
            r_prod      <= '0;
            r_mag_deg   <= '0;
            r_deg_out   <= '0;
            r_deg_valid <= 1'b0;
            r_done      <= 1'b0;
`ifdef RANGE_CHECK_EN
            r_error     <= 1'b0;
`endif
        end else begin
            r_deg_valid <= 1'b0;
            r_done      <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_rad   <= rad_q14;
`ifdef RANGE_CHECK_EN
                        r_error <= 1'b0;
`endif
                    end
                end
                S_ABS: begin
                    r_sign <= r_rad[15];
                    r_mag  <= w_mag;
                end
                S_MUL: begin
                    r_prod <= w_prod;
                end
                S_RND: begin
                    // Rounding on the magnitude gives half-away-from-zero once the sign is reapplied
                    r_mag_deg <= 9'((r_prod + RND_HALF) >> FRAC_SHIFT);
                end
                S_OUT: begin
                    r_deg_out   <= w_deg_val;
                    r_deg_valid <= 1'b1;
`ifdef RANGE_CHECK_EN
                    if (w_over) r_error <= 1'b1;
`endif
                end
                S_DONE: begin
                    r_done <= 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign deg_out   = r_deg_out;
    assign deg_valid = r_deg_valid;
    assign done      = r_done;
    assign busy      = (r_state != S_IDLE);

endmodule

// File: tb/tb_rad_q14_to_int_deg.sv
// tb/tb_rad_q14_to_int_deg.sv - directed self-checking bench for rad_q14_to_int_deg
module tb_rad_q14_to_int_deg;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        start = 1'b0;
    logic [15:0] rad_q14 = 16'd0;
    logic [15:0] deg_out;
    logic        deg_valid;
    logic        busy;
    logic        error;
    logic        done;

    int tests_run = 0;
    int tests_failed = 0;

    rad_q14_to_int_deg dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .rad_q14   (rad_q14),
        .deg_out   (deg_out),
        .deg_valid (deg_valid),
        .busy      (busy),
        .error     (error),
        .done      (done)
    );

    always #5 clk = ~clk;

    // Pulses start for one edge (k), scrambles rad_q14 afterwards, observes k..k+9 at #1 after each edge.
    task automatic convert(input logic [15:0] v, output logic [15:0] d, output int v_at, output int d_at,
                           output int nv, output int nd, output int nb, output logic e0, output logic e_end);
        d = 16'hDEAD; v_at = -1; d_at = -1; nv = 0; nd = 0; nb = 0;
        @(negedge clk);
        start = 1'b1;
        rad_q14 = v;
        @(posedge clk);
        #1;
        start = 1'b0;
        rad_q14 = 16'h5A5A;
        e0 = error;
        for (int j = 0; j < 10; j++) begin
            if (j > 0) begin
                @(posedge clk);
                #1;
            end
            if (busy) nb++;
            if (deg_valid) begin nv++; v_at = j; d = deg_out; end
            if (done) begin nd++; d_at = j; end
        end
        e_end = error;
    endtask

    task automatic test_reset();
        rst = 1'b0;
        start = 1'b1;
        rad_q14 = 16'd25740;
        for (int c = 0; c < 2; c++) begin
            @(posedge clk);
            #1;
            tests_run++;
            if ({deg_out, deg_valid, done, busy, error} !== 20'd0) begin
                tests_failed++;
                $display("FAIL reset cyc%0d: deg_out=%0d valid=%b done=%b busy=%b error=%b, need all 0",
                         c, deg_out, deg_valid, done, busy, error);
            end
        end
        @(negedge clk);
        start = 1'b0;
        rst = 1'b1;
        @(posedge clk);
        #1;
        tests_run++;
        if (busy !== 1'b0 || done !== 1'b0) begin
            tests_failed++;
            $display("FAIL reset_release: busy=%b done=%b, need 0 0", busy, done);
        end
    endtask

    task automatic test_round_trip();
        logic [15:0] vin [4] = '{16'd25740, 16'd286, 16'hCDBA, 16'd0};
        logic [15:0] vexp [4] = '{16'd90, 16'd1, 16'hFFD3, 16'd0};
        logic [15:0] d, hold;
        int v_at, d_at, nv, nd, nb;
        logic e0, e1;
        for (int i = 0; i < 4; i++) begin
            convert(vin[i], d, v_at, d_at, nv, nd, nb, e0, e1);
            tests_run++;
            if (d !== vexp[i] || nv != 1) begin
                tests_failed++;
                $display("FAIL round_trip[%0d] in=%0d: deg_out=%0d nvalid=%0d, need %0d nvalid=1",
                         i, $signed(vin[i]), $signed(d), nv, $signed(vexp[i]));
            end
            tests_run++;
            if (v_at != 4 || d_at != 5 || nd != 1) begin
                tests_failed++;
                $display("FAIL timing[%0d]: valid_at=k+%0d done_at=k+%0d ndone=%0d, need k+4 k+5 1",
                         i, v_at, d_at, nd);
            end
            tests_run++;
            if (nb != 5) begin
                tests_failed++;
                $display("FAIL busy_window[%0d]: busy samples=%0d, need 5", i, nb);
            end
        end
        hold = deg_out;
        repeat (3) @(posedge clk);
        #1;
        tests_run++;
        if (deg_out !== 16'd0 || hold !== 16'd0) begin
            tests_failed++;
            $display("FAIL hold: deg_out=%0d (before %0d), need 0", $signed(deg_out), $signed(hold));
        end
    endtask

    task automatic test_extremes();
        logic [15:0] d;
        int v_at, d_at, nv, nd, nb;
        logic e0, e1;
`ifdef RANGE_CHECK_EN
        convert(16'd32767, d, v_at, d_at, nv, nd, nb, e0, e1);
        tests_run++;
        if (d !== 16'd90 || e1 !== 1'b1) begin
            tests_failed++;
            $display("FAIL sat_pos: deg_out=%0d error=%b, need 90 1", $signed(d), e1);
        end
        convert(16'd8192, d, v_at, d_at, nv, nd, nb, e0, e1);
        tests_run++;
        if (e0 !== 1'b0 || d !== 16'd29 || e1 !== 1'b0) begin
            tests_failed++;
            $display("FAIL err_clear: error@accept=%b deg_out=%0d error=%b, need 0 29 0", e0, $signed(d), e1);
        end
        convert(16'h8000, d, v_at, d_at, nv, nd, nb, e0, e1);
        tests_run++;
        if (d !== 16'hFFA6 || e1 !== 1'b1) begin
            tests_failed++;
            $display("FAIL sat_neg: deg_out=%0d error=%b, need -90 1", $signed(d), e1);
        end
`else
        convert(16'd32767, d, v_at, d_at, nv, nd, nb, e0, e1);
        tests_run++;
        if (d !== 16'd115 || e1 !== 1'b0) begin
            tests_failed++;
            $display("FAIL max_pos: deg_out=%0d error=%b, need 115 0", $signed(d), e1);
        end
        convert(16'h8000, d, v_at, d_at, nv, nd, nb, e0, e1);
        tests_run++;
        if (d !== 16'hFF8D || e1 !== 1'b0) begin
            tests_failed++;
            $display("FAIL max_neg: deg_out=%0d error=%b, need -115 0", $signed(d), e1);
        end
        convert(16'd8192, d, v_at, d_at, nv, nd, nb, e0, e1);
        tests_run++;
        if (d !== 16'd29) begin
            tests_failed++;
            $display("FAIL round_up: deg_out=%0d, need 29", $signed(d));
        end
`endif
    endtask

    task automatic test_busy_reject();
        int nd_first = 0;
        int nd_total = 0;
        int nv = 0;
        logic [15:0] d1 = 16'hDEAD;
        logic [15:0] d2 = 16'hDEAD;
        int v2_at = -1;
        @(negedge clk);
        start = 1'b1;
        rad_q14 = 16'd25740;
        @(posedge clk);
        #1;
        start = 1'b0;
        for (int j = 1; j <= 14; j++) begin
            @(negedge clk);
            if (j == 2 || j == 6) begin
                start = 1'b1;
                rad_q14 = 16'hCDBA;
            end else begin
                start = 1'b0;
            end
            @(posedge clk);
            #1;
            if (done) begin
                nd_total++;
                if (j <= 6) nd_first++;
            end
            if (deg_valid) begin
                nv++;
                if (nv == 1) d1 = deg_out;
                else begin d2 = deg_out; v2_at = j; end
            end
        end
        start = 1'b0;
        tests_run++;
        if (nd_first != 1 || d1 !== 16'd90) begin
            tests_failed++;
            $display("FAIL busy_reject: done count=%0d deg_out=%0d, need 1 90", nd_first, $signed(d1));
        end
        tests_run++;
        if (nd_total != 2 || nv != 2 || d2 !== 16'hFFD3 || v2_at != 10) begin
            tests_failed++;
            $display("FAIL restart_k6: dones=%0d valids=%0d deg_out=%0d valid_at=k+%0d, need 2 2 -45 k+10",
                     nd_total, nv, $signed(d2), v2_at);
        end
    endtask

    task automatic test_reset_mid_op();
        int nv = 0;
        int nd = 0;
        logic [15:0] d;
        int v_at, d_at, nvv, ndd, nb;
        logic e0, e1;
        @(negedge clk);
        start = 1'b1;
        rad_q14 = 16'd25740;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        tests_run++;
        if (busy !== 1'b0 || deg_out !== 16'd0 || error !== 1'b0 || deg_valid !== 1'b0 || done !== 1'b0) begin
            tests_failed++;
            $display("FAIL abort_state: busy=%b deg_out=%0d error=%b valid=%b done=%b, need 0 0 0 0 0",
                     busy, $signed(deg_out), error, deg_valid, done);
        end
        @(negedge clk);
        rst = 1'b1;
        for (int j = 0; j < 8; j++) begin
            @(posedge clk);
            #1;
            if (deg_valid) nv++;
            if (done) nd++;
        end
        tests_run++;
        if (nv != 0 || nd != 0 || deg_out !== 16'd0) begin
            tests_failed++;
            $display("FAIL abort_quiet: valids=%0d dones=%0d deg_out=%0d, need 0 0 0", nv, nd, $signed(deg_out));
        end
        convert(16'd286, d, v_at, d_at, nvv, ndd, nb, e0, e1);
        tests_run++;
        if (d !== 16'd1 || v_at != 4 || d_at != 5) begin
            tests_failed++;
            $display("FAIL after_abort: deg_out=%0d valid_at=k+%0d done_at=k+%0d, need 1 k+4 k+5",
                     $signed(d), v_at, d_at);
        end
    endtask

    initial begin
        test_reset();
        test_round_trip();
        test_extremes();
        test_busy_reject();
        test_reset_mid_op();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
